pipe_skid_reg: RTL and testbench
================================

Name: pipe_skid_reg

Overview:
- Parametrised successor to the fixed-field, free-running inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- A single WIDTH-bit stage register with a valid/ready handshake, a 2-entry skid buffer and synchronous flush.
- Each producer/consumer stage pair can stall independently. in_ready is registered, so stall paths do not chain combinationally through the pipeline.
- Instantiated once per pipeline boundary, with the stage's control and data fields concatenated onto in_data.

Parameters:
- WIDTH, 32, width of the payload carried through the stage.
- RESET_DATA, {WIDTH{1'b0}}, value loaded into both data registers on reset (and on flush when CLEAR_ON_FLUSH=1).
- CLEAR_ON_FLUSH, 1, 1 = flush also overwrites data registers with RESET_DATA; 0 = flush clears only valid bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- flush  input  1  synchronous kill of all held entries (branch/jump squash).
- in_valid  input  1  producer has a payload on in_data.
- in_ready  output  1  registered; stage can accept a payload this cycle.
- in_data  input  WIDTH  producer payload.
- out_valid  output  1  out_data holds a valid payload.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  WIDTH  payload to consumer.
- occupancy  output  2  number of held entries: 0, 1 or 2.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n); sampled only on the clk rising edge.
- Storage: main register (main_valid, main_data) and skid register (skid_valid, skid_data).
  - out_valid = main_valid; out_data = main_data.
  - occupancy = main_valid + skid_valid.
- Handshakes: in_accept = in_valid & in_ready; out_accept = out_valid & out_ready.
- Reset (rst_n=0 at an edge):
  - main_valid=0, skid_valid=0, main_data=skid_data=RESET_DATA.
  - in_ready=1, out_valid=0, occupancy=0.
  - Handshakes in a reset cycle are ignored.
- State encoding is implied by the valid bits. States: EMPTY (0,0), ONE (1,0), FULL (1,1). (0,1) is illegal and never reached.
- EMPTY: in_accept -> main<=in_data, go to ONE. Otherwise hold.
- ONE:
  - in_accept & out_accept -> main<=in_data, stay ONE.
  - in_accept only -> skid<=in_data, go to FULL.
  - out_accept only -> go to EMPTY (main_data retained, not cleared).
  - Neither -> hold.
- FULL: in_ready=0, so no input is accepted.
  - out_accept -> main<=skid_data, skid_valid<=0, go to ONE.
  - Otherwise hold.
- in_ready is registered and equals !skid_valid for the next state, i.e. 1 in EMPTY/ONE and 0 in FULL.
- Ordering: strict FIFO order; no payload duplicated or lost except by flush.
- Latency: 1 cycle from in_accept to out_valid when EMPTY.
- Throughput: one payload per cycle sustained while out_ready=1.
- Flush (rst_n=1, flush=1 at an edge):
  - Next state EMPTY; in_ready=1 next cycle.
  - The payload offered on the flush cycle is dropped, even if in_accept is true.
  - A consumer handshake on the flush cycle still counts as consumed by the consumer; the stage just empties.
  - Data registers become RESET_DATA iff CLEAR_ON_FLUSH=1.
- Priority: reset > flush > normal handshakes.
- Stability: while out_valid=1 and out_ready=0, out_data must not change. While in_ready=0, in_data is ignored.
- Reset mid-operation: any held entries are discarded, exactly as on flush with CLEAR_ON_FLUSH=1.

Test Plan:
- Reset then streaming:
  - Stimulus: rst_n low 2 cycles, release; in_valid=1 with data 1,2,3,4 on consecutive cycles; out_ready=1.
  - Response: out_valid rises 1 cycle after the first accept; out_data 1,2,3,4 on consecutive cycles; occupancy never exceeds 1.
- Backpressure fill:
  - Stimulus: out_ready=0, offer 0xA then 0xB.
  - Response: occupancy goes 1 then 2; in_ready=0 the cycle after 0xB is accepted; 0xC is held off. Raise out_ready: outputs 0xA, 0xB, 0xC in order, and in_ready returns to 1 one cycle after the first out_accept.
- Stall stability:
  - Stimulus: out_ready toggles randomly.
  - Response: out_data is constant while out_valid & !out_ready; scoreboard shows zero loss and zero duplication over 1000 payloads.
- Flush when FULL:
  - Stimulus: flush=1 with in_valid=1 and data 0xFF.
  - Response: next cycle occupancy=0, out_valid=0, in_ready=1, out_data=RESET_DATA; 0xFF never appears at the output.
- CLEAR_ON_FLUSH=0:
  - Stimulus: flush while ONE with main_data=0x55.
  - Response: out_valid=0, out_data stays 0x55.
- Reset mid-stream:
  - Stimulus: rst_n=0 while FULL, with in_valid=1 and out_ready=1.
  - Response: next cycle occupancy=0, in_ready=1, no handshake is counted, and out_data=RESET_DATA.

Source files
------------

// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle between a pipeline stage register and its producer/consumer.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface pipe_skid_reg_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    // Surrounding logic: drives the producer side and the consumer's ready.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    // The stage register itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with a valid/ready handshake, a 2-entry skid buffer,
// a registered in_ready and a synchronous flush.
module pipe_skid_reg #(
    parameter int               WIDTH          = 32,
    parameter logic [WIDTH-1:0] RESET_DATA     = {WIDTH{1'b0}},
    parameter bit               CLEAR_ON_FLUSH = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    pipe_skid_reg_if.slave       bus,
    output logic [1:0]           state_o
);
    // State is fully implied by the two valid bits; (main=0, skid=1) is unreachable.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_FULL  = 2'b11
    } state_t;

    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             in_ready_q,   in_ready_d;
    logic             in_accept;
    logic             out_accept;
    state_t           state;

    assign state      = state_t'({skid_valid_q, main_valid_q});
    assign in_accept  = bus.in_valid & in_ready_q;
    assign out_accept = main_valid_q & bus.out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            // The offered payload is dropped; a consumer handshake simply empties the stage.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            if (CLEAR_ON_FLUSH) begin
                main_data_d = RESET_DATA;
                skid_data_d = RESET_DATA;
            end
        end else begin
            case (state)
                S_EMPTY: begin
                    if (in_accept) begin
                        main_valid_d = 1'b1;
                        main_data_d  = bus.in_data;
                    end
                end
                S_ONE: begin
                    if (in_accept && out_accept) begin
                        main_data_d = bus.in_data;
                    end else if (in_accept) begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = bus.in_data;
                    end else if (out_accept) begin
                        main_valid_d = 1'b0;
                    end
                end
                S_FULL: begin
                    if (out_accept) begin
                        main_data_d  = skid_data_q;
                        skid_valid_d = 1'b0;
                    end
                end
                default: begin
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                end
            endcase
        end
        // Ready depends only on next-state storage, so stalls never chain combinationally.
        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= RESET_DATA;
            skid_data_q  <= RESET_DATA;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = main_valid_q;
    assign bus.out_data  = main_data_q;
    assign bus.occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
    assign state_o       = state;
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: a FIFO-level model checks instance A every cycle, directed
// literal checks pin the model, and instance B covers the no-clear flush variant.
module tb_pipe_skid_reg;
    localparam int         W     = 8;
    localparam logic [7:0] RST_A = 8'hE5;
    localparam logic [7:0] RST_B = 8'h00;

    logic clk = 1'b0;
    logic rst_n;
    logic flush_a;
    logic flush_b;
    logic [1:0] state_a;
    logic [1:0] state_b;

    pipe_skid_reg_if #(.WIDTH(W)) ifa ();
    pipe_skid_reg_if #(.WIDTH(W)) ifb ();

    pipe_skid_reg #(.WIDTH(W), .RESET_DATA(RST_A), .CLEAR_ON_FLUSH(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush_a), .bus(ifa.slave), .state_o(state_a)
    );
    pipe_skid_reg #(.WIDTH(W), .RESET_DATA(RST_B), .CLEAR_ON_FLUSH(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush_b), .bus(ifb.slave), .state_o(state_b)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model of instance A: a queue of held payloads (max 2)
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mdl_main;
    bit           mdl_on = 1'b0;
    bit           mdl_ai;
    bit           mdl_ao;

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            mdl_main = RST_A;
            mdl_on   = 1'b1;
        end else if (mdl_on) begin
            if (flush_a) begin
                exp_q.delete();
                mdl_main = RST_A;
            end else begin
                mdl_ai = ifa.in_valid && (exp_q.size() < 2);
                mdl_ao = ifa.out_ready && (exp_q.size() > 0);
                if (mdl_ao) void'(exp_q.pop_front());
                if (mdl_ai) exp_q.push_back(ifa.in_data);
                if (exp_q.size() > 0) mdl_main = exp_q[0];
            end
        end
    end

    // Compare process plus stall-stability and received-payload tracking
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_data;
    bit           stream_on = 1'b0;
    int           rx_cnt = 0;

    always @(negedge clk) begin
        if (mdl_on) begin
            chk("out_valid", 32'(ifa.out_valid), 32'(exp_q.size() > 0));
            chk("occupancy", 32'(ifa.occupancy), 32'(exp_q.size()));
            chk("in_ready",  32'(ifa.in_ready),  32'(exp_q.size() < 2));
            chk("out_data",  32'(ifa.out_data),  32'(mdl_main));
            if (prev_stall && ifa.out_valid)
                chk("stall_stable", 32'(ifa.out_data), 32'(prev_data));
            prev_stall = ifa.out_valid && !ifa.out_ready && !flush_a && rst_n;
            prev_data  = ifa.out_data;
            if (stream_on && ifa.out_valid && ifa.out_ready) rx_cnt++;
        end
    end

    int  sent;
    int  cyc;
    bit  acc;

    initial begin
        rst_n = 1'b0; flush_a = 1'b0; flush_b = 1'b0;
        ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(ifa.in_ready), 32'd1);
        chk("rst_occ", 32'(ifa.occupancy), 32'd0);
        chk("rst_out_data", 32'(ifa.out_data), 32'hE5);

        // Instance B: flush while holding 0x55 keeps the data, drops the valid
        ifb.in_valid = 1'b1; ifb.in_data = 8'h55;
        step();
        ifb.in_valid = 1'b0;
        @(negedge clk);
        chk("b_hold_data", 32'(ifb.out_data), 32'h55);
        chk("b_hold_occ", 32'(ifb.occupancy), 32'd1);
        flush_b = 1'b1;
        step();
        flush_b = 1'b0;
        @(negedge clk);
        chk("b_flush_valid", 32'(ifb.out_valid), 32'd0);
        chk("b_flush_data", 32'(ifb.out_data), 32'h55);
        chk("b_flush_occ", 32'(ifb.occupancy), 32'd0);
        chk("b_flush_ready", 32'(ifb.in_ready), 32'd1);

        // Streaming 1..4 with out_ready=1
        ifa.in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            ifa.in_data = 8'(k);
            step();
            @(negedge clk);
            chk("stream_data", 32'(ifa.out_data), 32'(k));
            chk("stream_occ", 32'(ifa.occupancy), 32'd1);
        end
        ifa.in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("drain_valid", 32'(ifa.out_valid), 32'd0);
        chk("drain_keep", 32'(ifa.out_data), 32'd4);

        // Backpressure fill
        ifa.out_ready = 1'b0;
        ifa.in_valid = 1'b1; ifa.in_data = 8'h0A;
        step();
        ifa.in_data = 8'h0B;
        step();
        @(negedge clk);
        chk("bp_occ2", 32'(ifa.occupancy), 32'd2);
        chk("bp_ready0", 32'(ifa.in_ready), 32'd0);
        chk("bp_state", 32'(state_a), 32'd3);
        ifa.in_data = 8'h0C;
        step();
        @(negedge clk);
        chk("bp_head", 32'(ifa.out_data), 32'h0A);
        ifa.out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("bp_out_b", 32'(ifa.out_data), 32'h0B);
        chk("bp_ready1", 32'(ifa.in_ready), 32'd1);
        step();
        ifa.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_out_c", 32'(ifa.out_data), 32'h0C);
        step();

        // Flush while FULL with 0xFF offered
        ifa.out_ready = 1'b0;
        ifa.in_valid = 1'b1; ifa.in_data = 8'h01;
        step();
        ifa.in_data = 8'h02;
        step();
        ifa.in_data = 8'hFF; flush_a = 1'b1; ifa.out_ready = 1'b1;
        step();
        flush_a = 1'b0; ifa.in_valid = 1'b0;
        @(negedge clk);
        chk("fl_occ", 32'(ifa.occupancy), 32'd0);
        chk("fl_valid", 32'(ifa.out_valid), 32'd0);
        chk("fl_ready", 32'(ifa.in_ready), 32'd1);
        chk("fl_data", 32'(ifa.out_data), 32'hE5);
        step(); step();

        // Reset while FULL with handshakes offered
        ifa.out_ready = 1'b0;
        ifa.in_valid = 1'b1; ifa.in_data = 8'h03;
        step();
        ifa.in_data = 8'h04;
        step();
        rst_n = 1'b0; ifa.in_data = 8'h09; ifa.out_ready = 1'b1;
        step();
        rst_n = 1'b1; ifa.in_valid = 1'b0;
        @(negedge clk);
        chk("rm_occ", 32'(ifa.occupancy), 32'd0);
        chk("rm_ready", 32'(ifa.in_ready), 32'd1);
        chk("rm_data", 32'(ifa.out_data), 32'hE5);

        // Random stalls over 1000 payloads
        stream_on = 1'b1;
        sent = 0; cyc = 0;
        while ((sent < 1000 || rx_cnt < 1000) && cyc < 20000) begin
            if (!ifa.in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
                ifa.in_valid = 1'b1;
                ifa.in_data  = sent[7:0];
            end
            ifa.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = ifa.in_valid && ifa.in_ready;
            step();
            cyc++;
            if (acc) begin
                sent++;
                ifa.in_valid = 1'b0;
            end
        end
        stream_on = 1'b0;
        chk("stream_timeout", 32'(cyc < 20000), 32'd1);
        chk("stream_rx", 32'(rx_cnt), 32'd1000);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
